// File: rtl/fpc_tx_sched_if.sv
// Handshake and encoder-side signals of the FPC transmit scheduler.
// master = requester/encoder side, slave = the scheduler itself.
interface fpc_tx_sched_if #(
  parameter int NREQ = 4
) ();
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0][31:0]  req_data;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        req_ready;
  logic [31:0]            enc_din;
  logic                   enc_load;
  logic                   bus_valid;
  logic [SW-1:0]          bus_src;
  logic                   busy;

  modport master (
    output req_valid, req_data, req_last,
    input  req_ready, enc_din, enc_load, bus_valid, bus_src, busy
  );

  modport slave (
    input  req_valid, req_data, req_last,
    output req_ready, enc_din, enc_load, bus_valid, bus_src, busy
  );
endinterface

// File: rtl/fpc_tx_sched.sv
// Round-robin burst scheduler feeding one shared registered FPC encoder.
// Optional FPC_STALL_RELEASE_EN: drop the grant after IDLE_TO stalled cycles.
module fpc_tx_sched #(
  parameter int NREQ      = 4,
  parameter int BURST_MAX = 8,
  parameter int ENC_LAT   = 1,
  parameter int IDLE_TO   = 4
) (
  input  logic           clk,
  input  logic           rst,
  fpc_tx_sched_if.slave  sif
);
  localparam int         SW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] BMAX = 8'(BURST_MAX);

  typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

  state_t                  state_q, state_d;
  logic [SW-1:0]           grant_q, grant_d, last_grant_q, last_grant_d;
  logic [SW-1:0]           pick, idx;
  logic                    pick_vld;
  logic [7:0]              beat_q, beat_d, beat_inc;
  logic                    hs, done, stall_rel;
  logic [31:0]             enc_din_q;
  logic [ENC_LAT:0]        vld_pipe;
  logic [ENC_LAT:0][SW-1:0] src_pipe;

  // Rotating priority: start the search just after the last served requester.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = SW'((int'(last_grant_q) + k) % NREQ);
      if (!pick_vld && sif.req_valid[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  assign hs       = (state_q == XFER) && sif.req_valid[grant_q];
  assign beat_inc = beat_q + 8'd1;
  assign done     = hs && (sif.req_last[grant_q] || (beat_inc == BMAX));

`ifdef FPC_STALL_RELEASE_EN
  logic [7:0] stall_q;

  assign stall_rel = (state_q == XFER) && !hs && ((stall_q + 8'd1) == 8'(IDLE_TO));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          stall_q <= '0;
    else if (state_q != XFER || hs)    stall_q <= '0;
    else                               stall_q <= stall_q + 8'd1;
  end
`else
  assign stall_rel = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= SW'(NREQ - 1);
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_q       <= beat_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_d       = beat_q;
    case (state_q)
      IDLE: if (pick_vld) begin
        grant_d = pick;
        state_d = GRANT;
      end
      GRANT: begin
        beat_d  = '0;
        state_d = XFER;
      end
      XFER: begin
        if (hs) beat_d = beat_inc;
        if (done || stall_rel) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // enc_din only moves on a handshake so the encoded bus stays quiet when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enc_din_q <= '0;
      vld_pipe  <= '0;
      src_pipe  <= '0;
    end else begin
      if (hs) enc_din_q <= sif.req_data[grant_q];
      vld_pipe <= {vld_pipe[ENC_LAT-1:0], hs};
      src_pipe <= {src_pipe[ENC_LAT-1:0], grant_q};
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_rdy
    assign sif.req_ready[i] = (state_q == XFER) && (grant_q == SW'(i));
  end

  assign sif.enc_din   = enc_din_q;
  assign sif.enc_load  = vld_pipe[0];
  assign sif.bus_valid = vld_pipe[ENC_LAT];
  assign sif.bus_src   = src_pipe[ENC_LAT];
  assign sif.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_fpc_tx_sched.sv
// Directed bench for fpc_tx_sched: single burst, reset mid-burst, round-robin,
// burst cap with stall, and an ENC_LAT=3 instance.
module tb_fpc_tx_sched;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fpc_tx_sched_if #(.NREQ(NREQ)) sif ();
  fpc_tx_sched_if #(.NREQ(NREQ)) if3 ();

  fpc_tx_sched #(.NREQ(NREQ), .BURST_MAX(8), .ENC_LAT(1), .IDLE_TO(4)) u_dut (
    .clk(clk), .rst(rst), .sif(sif)
  );
  fpc_tx_sched #(.NREQ(NREQ), .BURST_MAX(8), .ENC_LAT(3), .IDLE_TO(4)) u_dut3 (
    .clk(clk), .rst(rst), .sif(if3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input bit which, input logic [3:0] exp, input string tag);
    for (int i = 0; i < 12; i++) begin
      if ((which ? if3.req_ready : sif.req_ready) != '0) break;
      tick();
    end
    chk(tag, which ? if3.req_ready : sif.req_ready, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdy"},  sif.req_ready, 0);
    chk({tag, "_din"},  sif.enc_din,   0);
    chk({tag, "_load"}, sif.enc_load,  0);
    chk({tag, "_bv"},   sif.bus_valid, 0);
    chk({tag, "_src"},  sif.bus_src,   0);
    chk({tag, "_busy"}, sif.busy,      0);
  endtask

  initial begin
    sif.req_valid = '0; sif.req_last = '0; sif.req_data = '0;
    if3.req_valid = '0; if3.req_last = '0; if3.req_data = '0;

    // reset state
    #3;
    chk_zero("rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tick();

    // single burst from requester 2: A, B, C(last)
    sif.req_valid[2] = 1'b1; sif.req_data[2] = 32'hA;
    tick();
    chk("sb_busy", sif.busy, 1);
    chk("sb_rdy_early", sif.req_ready, 0);
    tick();
    chk("sb_grant", sif.req_ready, 4'b0100);
    tick();
    chk("sb_dinA", sif.enc_din, 32'hA);
    chk("sb_loadA", sif.enc_load, 1);
    chk("sb_bv0", sif.bus_valid, 0);
    sif.req_data[2] = 32'hB;
    tick();
    chk("sb_dinB", sif.enc_din, 32'hB);
    chk("sb_loadB", sif.enc_load, 1);
    chk("sb_bvA", sif.bus_valid, 1);
    chk("sb_srcA", sif.bus_src, 2);
    sif.req_data[2] = 32'hC; sif.req_last[2] = 1'b1;
    tick();
    chk("sb_dinC", sif.enc_din, 32'hC);
    chk("sb_bvB", sif.bus_valid, 1);
    chk("sb_rdy_drop", sif.req_ready, 0);
    chk("sb_idle", sif.busy, 0);
    sif.req_valid[2] = 1'b0; sif.req_last[2] = 1'b0;
    tick();
    chk("sb_load_off", sif.enc_load, 0);
    chk("sb_bvC", sif.bus_valid, 1);
    chk("sb_srcC", sif.bus_src, 2);
    tick();
    chk("sb_bv_off", sif.bus_valid, 0);
    chk("sb_hold", sif.enc_din, 32'hC);

    // reset during the 2nd word of a requester-3 burst
    sif.req_valid[3] = 1'b1; sif.req_data[3] = 32'h30;
    wait_rdy(0, 4'b1000, "mr_grant");
    tick();
    chk("mr_din1", sif.enc_din, 32'h30);
    sif.req_data[3] = 32'h31;
    #2 rst = 1'b0;
    #1;
    chk_zero("mr");
    sif.req_valid = '1; sif.req_last = '1;
    for (int i = 0; i < NREQ; i++) sif.req_data[i] = 32'h100 + i;
    @(negedge clk);
    rst = 1'b1;

    // round robin of 1-word bursts, order must be 0,1,2,3,0
    for (int n = 0; n < 5; n++) begin
      wait_rdy(0, 4'(1 << (n % 4)), "rr_grant");
      tick();
      chk("rr_din", sif.enc_din, 32'h100 + (n % 4));
      chk("rr_load", sif.enc_load, 1);
      if (n == 4) sif.req_valid = '0;
      tick();
      chk("rr_bv", sif.bus_valid, 1);
      chk("rr_src", sif.bus_src, n % 4);
    end
    sif.req_last = '0;

    // burst cap: requester 1 never sets last, requester 3 waiting
    sif.req_valid[1] = 1'b1; sif.req_data[1] = 32'h200;
    sif.req_valid[3] = 1'b1; sif.req_data[3] = 32'h300; sif.req_last[3] = 1'b1;
    wait_rdy(0, 4'b0010, "cap_grant");
    for (int w = 0; w < 8; w++) begin
      tick();
      chk("cap_din", sif.enc_din, 32'h200 + w);
      chk("cap_load", sif.enc_load, 1);
      sif.req_data[1] = 32'h201 + w;
    end
    chk("cap_drop", sif.req_ready, 0);
    wait_rdy(0, 4'b1000, "cap_next");
    tick();
    chk("cap_din3", sif.enc_din, 32'h300);
    sif.req_valid[3] = 1'b0; sif.req_last[3] = 1'b0;

    // stall: grantee drops valid for 10 cycles mid-burst
    wait_rdy(0, 4'b0010, "st_grant");
    tick();
    chk("st_din", sif.enc_din, 32'h208);
    sif.req_valid[1] = 1'b0;
    for (int s = 0; s < 10; s++) begin
      tick();
      chk("st_load", sif.enc_load, 0);
      chk("st_hold", sif.enc_din, 32'h208);
`ifdef FPC_STALL_RELEASE_EN
      chk("st_rdy", sif.req_ready, (s < 3) ? 4'b0010 : 4'b0000);
`else
      chk("st_rdy", sif.req_ready, 4'b0010);
`endif
    end
    sif.req_valid[1] = 1'b1; sif.req_data[1] = 32'h209; sif.req_last[1] = 1'b1;
    wait_rdy(0, 4'b0010, "st_resume");
    tick();
    chk("st_din2", sif.enc_din, 32'h209);
    chk("st_load2", sif.enc_load, 1);
    sif.req_valid[1] = 1'b0; sif.req_last[1] = 1'b0;
    tick();
    chk("st_idle", sif.busy, 0);

    // ENC_LAT=3 instance: bus_valid exactly 3 cycles after enc_load
    if3.req_valid[2] = 1'b1; if3.req_data[2] = 32'h55; if3.req_last[2] = 1'b1;
    wait_rdy(1, 4'b0100, "l3_grant");
    tick();
    chk("l3_load", if3.enc_load, 1);
    chk("l3_din", if3.enc_din, 32'h55);
    if3.req_valid[2] = 1'b0; if3.req_last[2] = 1'b0;
    tick();
    chk("l3_bv1", if3.bus_valid, 0);
    tick();
    chk("l3_bv2", if3.bus_valid, 0);
    tick();
    chk("l3_bv3", if3.bus_valid, 1);
    chk("l3_src", if3.bus_src, 2);
    tick();
    chk("l3_bv4", if3.bus_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
